// File: rtl/red_pitaya_dac_pkg.sv
// red_pitaya_dac_pkg: shared widths and FSM state encodings for the DAC slew limiter
package red_pitaya_dac_pkg;
  localparam int DW_DEF = 14;
  localparam int DIV_W_DEF = 16;
  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_UP = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;
endpackage

// File: rtl/red_pitaya_tick_div.sv
// red_pitaya_tick_div: tick every period+1 clocks, restartable by clr
module red_pitaya_tick_div #(
  parameter int DIV_W = red_pitaya_dac_pkg::DIV_W_DEF
) (
  input  logic             dac_clk_i,
  input  logic             dac_rst_i,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = cnt >= period;
  // count clocks between ticks, restarting on clear or after each tick
  always_ff @(posedge dac_clk_i or posedge dac_rst_i)
    if (dac_rst_i) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/red_pitaya_dac_slew.sv
// red_pitaya_dac_slew: slew-rate limited ramp-up/ramp-down of the DAC sample on enable changes
module red_pitaya_dac_slew
  import red_pitaya_dac_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rst_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic                 en_i,
  input  logic        [DW-1:0] set_slew_i,
  input  logic     [DIV_W-1:0] set_div_i,
  output logic signed [DW-1:0] dac_o,
  output logic                 busy_o,
  output logic           [1:0] state_o
);
  localparam logic signed [DW:0] SMAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] SMIN = ~SMAX;
  logic [1:0] state, st_nx;
  logic tick, near, mv, clr;
  logic signed [DW-1:0] tgt, sat;
  logic signed [DW:0] diff, step;
  logic [DW:0] mag;
  assign tgt = state == ST_DOWN ? '0 : dat_i;
  assign diff = {tgt[DW-1], tgt} - {dac_o[DW-1], dac_o};
  assign mag = diff[DW] ? -diff : diff;
  assign near = set_slew_i == '0 || mag <= {1'b0, set_slew_i};
  assign step = diff[DW] ? {dac_o[DW-1], dac_o} - {1'b0, set_slew_i} : {dac_o[DW-1], dac_o} + {1'b0, set_slew_i};
  assign sat = step > SMAX ? SMAX[DW-1:0] : step < SMIN ? SMIN[DW-1:0] : step[DW-1:0];
  assign mv = tick && ((state == ST_UP && en_i) || (state == ST_DOWN && !en_i));
  assign st_nx = state == ST_OFF   ? (en_i ? ST_UP : ST_OFF) :
                 state == ST_UP    ? (!en_i ? ST_DOWN : (tick && near) ? ST_TRACK : ST_UP) :
                 state == ST_TRACK ? (en_i ? ST_TRACK : ST_DOWN) :
                                     (en_i ? ST_UP : (tick && near) ? ST_OFF : ST_DOWN);
  assign clr = st_nx != state;
  assign busy_o = state == ST_UP || state == ST_DOWN;
  assign state_o = state;
  red_pitaya_tick_div #(.DIV_W(DIV_W)) u_div (
    .dac_clk_i(dac_clk_i),
    .dac_rst_i(dac_rst_i),
    .clr(clr),
    .period(set_div_i),
    .tick(tick)
  );
  // FSM and output sample: follow input in TRACK, step toward the target on ramp ticks
  always_ff @(posedge dac_clk_i or posedge dac_rst_i)
    if (dac_rst_i) begin
      state <= ST_OFF;
      dac_o <= '0;
    end else begin
      state <= st_nx;
      if (state == ST_TRACK && en_i) dac_o <= dat_i;
      else if (mv) dac_o <= near ? tgt : sat;
    end
endmodule
